// File: rtl/modulo_product.sv
// Bit-serial modular multiplier: o_mp = (i_a * i_b) mod i_n, one multiplier bit per cycle.
// Used to map operands into the Montgomery domain (i_b = 2^WIDTH) ahead of the Montgomery stage.
module modulo_product #(
  parameter int WIDTH = 256
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_n,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH:0]   i_b,
  output logic [WIDTH-1:0] o_mp,
  output logic             o_busy,
  output logic             o_finished
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [WIDTH:0] n_r;
  logic [WIDTH:0] b_r;
  logic [WIDTH:0] t_r;
  logic [WIDTH:0] m_r;
  logic [CW-1:0]  cnt;

  logic [WIDTH:0] m_sum;
  logic [WIDTH:0] m_next;
  logic [WIDTH:0] t_sh;
  logic [WIDTH:0] t_next;
  logic           last;

  // m and t stay below n, so one conditional subtract keeps each reduced.
  always_comb begin
    m_sum  = m_r + t_r;
    m_next = m_r;
    if (b_r[cnt]) begin
      m_next = (m_sum >= n_r) ? (m_sum - n_r) : m_sum;
    end
    t_sh   = {t_r[WIDTH-1:0], 1'b0};
    t_next = (t_sh >= n_r) ? (t_sh - n_r) : t_sh;
    last   = (cnt == CW'(WIDTH));
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (i_start) state_next = S_CALC;
      S_CALC:  if (last) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= S_IDLE;
      n_r        <= '0;
      b_r        <= '0;
      t_r        <= '0;
      m_r        <= '0;
      cnt        <= '0;
      o_mp       <= '0;
      o_busy     <= 1'b0;
      o_finished <= 1'b0;
    end else begin
      state      <= state_next;
      o_busy     <= (state_next != S_IDLE);
      o_finished <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_start) begin
            n_r <= {1'b0, i_n};
            b_r <= i_b;
            t_r <= {1'b0, i_a};
            m_r <= '0;
            cnt <= '0;
          end
        end
        S_CALC: begin
          m_r <= m_next;
          t_r <= t_next;
          if (last) begin
            o_mp       <= m_next[WIDTH-1:0];
            o_finished <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_modulo_product.sv
// Self-checking bench for modulo_product: directed tables, random vectors vs. (a*b)%n,
// and hand-written sequences for restart, reset abort and back-to-back operation.
module tb_modulo_product;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst8, start8, busy8, fin8;
  logic [7:0]   n8, a8, mp8;
  logic [8:0]   b8;
  logic         rst256, start256, busy256, fin256;
  logic [255:0] n256, a256, mp256;
  logic [256:0] b256;

  modulo_product #(.WIDTH(8)) u8 (
    .i_clk(clk), .i_rst(rst8), .i_start(start8), .i_n(n8), .i_a(a8), .i_b(b8),
    .o_mp(mp8), .o_busy(busy8), .o_finished(fin8)
  );

  modulo_product #(.WIDTH(256)) u256 (
    .i_clk(clk), .i_rst(rst256), .i_start(start256), .i_n(n256), .i_a(a256), .i_b(b256),
    .o_mp(mp256), .o_busy(busy256), .o_finished(fin256)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] n;
    logic [7:0] a;
    logic [8:0] b;
    logic [7:0] exp;
  } vec8_t;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ref8(input logic [7:0] n, input logic [7:0] a, input logic [8:0] b);
    int p;
    p = (int'(a) * int'(b)) % int'(n);
    return 8'(p);
  endfunction

  function automatic logic [255:0] ref256(input logic [255:0] n, input logic [255:0] a,
                                          input logic [256:0] b);
    logic [520:0] p;
    logic [520:0] r;
    p = {265'b0, a} * {264'b0, b};
    r = p % {265'b0, n};
    return r[255:0];
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] x;
    for (int i = 0; i < 8; i++) x[i*32 +: 32] = $urandom;
    return x;
  endfunction

  // One operation; counts from the first negedge after the accept edge (c = 0).
  task automatic op8(input logic [7:0] n, input logic [7:0] a, input logic [8:0] b,
                     output logic [7:0] res, output int fin_at, output int fin_cnt,
                     output int busy_cnt);
    @(negedge clk);
    n8 = n; a8 = a; b8 = b; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    n8 = 8'($urandom); a8 = 8'($urandom); b8 = 9'($urandom);
    res = '0; fin_at = -1; fin_cnt = 0; busy_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (fin8) begin
        fin_cnt++;
        if (fin_at < 0) begin fin_at = c; res = mp8; end
      end
      if (busy8) busy_cnt++;
      else break;
      @(negedge clk);
    end
  endtask

  task automatic op256(input logic [255:0] n, input logic [255:0] a, input logic [256:0] b,
                       output logic [255:0] res, output int fin_at, output int busy_cnt);
    @(negedge clk);
    n256 = n; a256 = a; b256 = b; start256 = 1'b1;
    @(negedge clk);
    start256 = 1'b0;
    n256 = rand256(); a256 = rand256();
    res = '0; fin_at = -1; busy_cnt = 0;
    for (int c = 0; c < 300; c++) begin
      if (fin256 && fin_at < 0) begin fin_at = c; res = mp256; end
      if (busy256) busy_cnt++;
      else break;
      @(negedge clk);
    end
  endtask

  vec8_t        vecs[6];
  logic [7:0]   r8;
  logic [255:0] r256, nbig, e256;
  logic [256:0] bfull;
  int           fat, fcnt, bcnt;

  initial begin
    rst8 = 1'b1; start8 = 1'b0; n8 = '0; a8 = '0; b8 = '0;
    rst256 = 1'b1; start256 = 1'b0; n256 = '0; a256 = '0; b256 = '0;
    vecs[0] = '{n: 8'd13,  a: 8'd5,   b: 9'd256, exp: 8'd6};
    vecs[1] = '{n: 8'd251, a: 8'd250, b: 9'd256, exp: 8'd246};
    vecs[2] = '{n: 8'd13,  a: 8'd5,   b: 9'd0,   exp: 8'd0};
    vecs[3] = '{n: 8'd13,  a: 8'd7,   b: 9'd1,   exp: 8'd7};
    vecs[4] = '{n: 8'd13,  a: 8'd12,  b: 9'd511, exp: 8'd9};
    vecs[5] = '{n: 8'd255, a: 8'd254, b: 9'd256, exp: 8'd254};
    nbig  = {256{1'b1}} - 256'd188;
    bfull = {1'b1, 256'b0};

    #12;
    check("reset_mp8", mp8, 0);
    check("reset_busy8", busy8, 0);
    check("reset_fin8", fin8, 0);
    check("reset_mp256", mp256, 0);
    @(negedge clk);
    rst8 = 1'b0; rst256 = 1'b0;

    // Directed table; first entry also pins latency and busy length.
    for (int i = 0; i < 6; i++) begin
      op8(vecs[i].n, vecs[i].a, vecs[i].b, r8, fat, fcnt, bcnt);
      $display("dir8 n=%0d a=%0d b=%0d mp=%0d exp=%0d fin_at=%0d", vecs[i].n, vecs[i].a,
               vecs[i].b, r8, vecs[i].exp, fat);
      check("dir8_mp", r8, vecs[i].exp);
      check("dir8_latency", fat, 9);
      check("dir8_pulses", fcnt, 1);
      check("dir8_busy_cycles", bcnt, 10);
    end

    // Random vectors against (a*b) mod n.
    for (int i = 0; i < 1000; i++) begin
      logic [7:0] rn, ra;
      logic [8:0] rb;
      rn = 8'($urandom_range(3, 255)) | 8'd1;
      ra = 8'($urandom % rn);
      rb = 9'($urandom_range(0, 511));
      op8(rn, ra, rb, r8, fat, fcnt, bcnt);
      $display("rnd8 n=%0d a=%0d b=%0d mp=%0d exp=%0d", rn, ra, rb, r8, ref8(rn, ra, rb));
      check("rnd8_mp", r8, ref8(rn, ra, rb));
      check("rnd8_pulses", fcnt, 1);
    end

    // Restart request mid-calculation with different operands must be ignored.
    begin
      int fc, bc;
      logic [7:0] got;
      @(negedge clk);
      n8 = 8'd13; a8 = 8'd5; b8 = 9'd256; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0; fc = 0; bc = 0; got = '0;
      for (int c = 0; c < 40; c++) begin
        if (c == 3) begin start8 = 1'b1; n8 = 8'd251; a8 = 8'd250; b8 = 9'd3; end
        if (c == 4) start8 = 1'b0;
        if (fin8) begin fc++; got = mp8; end
        if (busy8) bc++;
        else break;
        @(negedge clk);
      end
      $display("restart8 mp=%0d pulses=%0d busy=%0d", got, fc, bc);
      check("restart_mp", got, 8'd6);
      check("restart_pulses", fc, 1);
      check("restart_busy_cycles", bc, 10);
    end

    // Start held high across three operations: accepts every WIDTH+3 cycles.
    begin
      logic [7:0] bn[3], ba[3], ex[3];
      logic [8:0] bb[3];
      int fins[$];
      logic [7:0] got[$];
      for (int j = 0; j < 3; j++) begin
        bn[j] = 8'($urandom_range(3, 255)) | 8'd1;
        ba[j] = 8'($urandom % bn[j]);
        bb[j] = 9'($urandom_range(0, 511));
        ex[j] = ref8(bn[j], ba[j], bb[j]);
      end
      @(negedge clk);
      n8 = bn[0]; a8 = ba[0]; b8 = bb[0]; start8 = 1'b1;
      for (int c = 0; c < 45; c++) begin
        @(negedge clk);
        if (c == 1) begin n8 = bn[1]; a8 = ba[1]; b8 = bb[1]; end
        if (c == 12) begin n8 = bn[2]; a8 = ba[2]; b8 = bb[2]; end
        if (c == 22) start8 = 1'b0;
        if (fin8) begin fins.push_back(c); got.push_back(mp8); end
      end
      check("b2b_pulse_count", fins.size(), 3);
      for (int j = 0; j < 3; j++) begin
        if (fins.size() > j) begin
          $display("b2b op%0d mp=%0d exp=%0d fin_at=%0d", j, got[j], ex[j], fins[j]);
          check("b2b_mp", got[j], ex[j]);
          check("b2b_fin_time", fins[j], 9 + 11 * j);
        end
      end
    end

    // Full-width Montgomery-domain conversions.
    op256(nbig, 256'd1, bfull, r256, fat, bcnt);
    $display("w256 a=1 mp=%0h fin_at=%0d", r256, fat);
    check("w256_one_mp", r256, 256'd189);
    check("w256_latency", fat, 257);
    check("w256_busy_cycles", bcnt, 258);
    op256(nbig, nbig - 256'd1, bfull, r256, fat, bcnt);
    $display("w256 a=n-1 mp=%0h", r256);
    check("w256_nm1_mp", r256, nbig - 256'd189);
    for (int i = 0; i < 4; i++) begin
      logic [255:0] rn, ra;
      logic [256:0] rb;
      rn = rand256() | {1'b1, 255'b0} | 256'd1;
      ra = rand256() % rn;
      rb = {1'($urandom), rand256()};
      op256(rn, ra, rb, r256, fat, bcnt);
      e256 = ref256(rn, ra, rb);
      $display("rnd256 mp=%0h exp=%0h", r256, e256);
      check("rnd256_mp", r256, e256);
    end

    // Asynchronous reset at cnt=100, asserted between clock edges.
    begin
      int fc;
      fc = 0;
      @(negedge clk);
      n256 = nbig; a256 = 256'd5; b256 = bfull; start256 = 1'b1;
      @(negedge clk);
      start256 = 1'b0;
      for (int c = 0; c < 100; c++) begin
        @(negedge clk);
        if (fin256) fc++;
      end
      rst256 = 1'b1;
      #1;
      $display("rst256 mp=%0h busy=%0b fin=%0b", mp256, busy256, fin256);
      check("abort_mp", mp256, 0);
      check("abort_busy", busy256, 0);
      check("abort_fin", fin256, 0);
      for (int c = 0; c < 3; c++) @(negedge clk);
      rst256 = 1'b0;
      for (int c = 0; c < 300; c++) begin
        @(negedge clk);
        if (fin256 || busy256) fc++;
      end
      check("abort_no_activity", fc, 0);
      op256(nbig, 256'd1, bfull, r256, fat, bcnt);
      $display("post_rst256 mp=%0h fin_at=%0d", r256, fat);
      check("post_reset_mp", r256, 256'd189);
      check("post_reset_latency", fat, 257);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
